// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// Imported by the picker and the arbiter top.
package fifo_arb_pkg;

    localparam int MAX_NUM_REQ = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Candidate index at distance off past last, wrapping modulo n.
    function automatic int rr_wrap(input int last, input int off, input int n);
        return (last + off) % n;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after 'last',
// wrapping; 'last' itself only wins when it is the sole requester.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDXW-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDXW-1:0]    o_idx,
    output logic               o_any
);

    logic found;
    int   cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        found    = 1'b0;
        cand     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = rr_wrap(int'(i_last), i, NUM_REQ);
            if (!found && i_req[cand]) begin
                found          = 1'b1;
                o_onehot[cand] = 1'b1;
                o_idx          = IDXW'(cand);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port among
// NUM_REQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_valid_s,
    output logic [DATA_WIDTH-1:0]         o_datain,
    input  logic                          i_ready_s,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]   BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [IDXW-1:0] LAST_RST   = IDXW'(NUM_REQ - 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]      gidx_q, gidx_d;
    logic [IDXW-1:0]      last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [IDXW-1:0]      pick_last;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDXW-1:0]      pick_idx;
    logic                 pick_any;

    logic                 in_grant;
    logic                 g_valid;
    logic [DATA_WIDTH-1:0] g_data;
    logic                 beat;
    logic                 rel;

    // While granted, the next winner is searched from the current owner.
    assign pick_last = (state_q == ARB_GRANT) ? gidx_q : last_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_picker (
        .i_req    (i_req_valid),
        .i_last   (pick_last),
        .o_onehot (pick_oh),
        .o_idx    (pick_idx),
        .o_any    (pick_any)
    );

    assign in_grant = (state_q == ARB_GRANT);
    assign g_valid  = i_req_valid[gidx_q];
    assign g_data   = i_req_data[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign beat     = in_grant & g_valid & i_ready_s;
    assign rel      = in_grant & ((beat & (cnt_q == BURST_LAST)) | ~g_valid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_GRANT: begin
                if (rel) begin
                    last_d = gidx_q;
                    cnt_d  = '0;
                    if (pick_any) begin
                        grant_d = pick_oh;
                        gidx_d  = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        o_valid_s   = 1'b0;
        o_datain    = '0;
        if (in_grant) begin
            o_valid_s           = g_valid;
            o_datain            = g_data;
            o_req_ready[gidx_q] = i_ready_s;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = in_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a behavioural
// round-robin burst model with a FIFO-fill model driving ready.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;
    localparam int FD = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             valid_s;
    logic [W-1:0]     datain;
    logic             ready_s;
    logic [N-1:0]     grant;
    logic             busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W),
        .MAX_BURST  (MB)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_valid_s   (valid_s),
        .o_datain    (datain),
        .i_ready_s   (ready_s),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: owner (-1 = nobody), last owner, beats in this grant.
    int           own;
    int           last;
    int           cnt;
    logic [N-1:0] vld;
    logic [W-1:0] dat [N];
    int           fifo_lvl;

    function automatic int pick(input logic [N-1:0] v, input int from);
        for (int k = 1; k <= N; k++) begin
            if (v[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = vld;
        for (int r = 0; r < N; r++) req_data[r*W +: W] = dat[r];
        ready_s = (fifo_lvl < FD);
    endtask

    task automatic model_reset();
        own  = -1;
        last = N - 1;
        cnt  = 0;
    endtask

    initial begin
        int          p_on, p_cont, p_drain;
        logic [N-1:0] exp_ready;
        logic        beat;
        int          beat_r;
        logic        rel;

        rst_n    = 1'b0;
        vld      = '1;
        fifo_lvl = 0;
        for (int r = 0; r < N; r++) dat[r] = $urandom;
        model_reset();
        drive();

        for (int cyc = 0; cyc < 1600; cyc++) begin
            if (cyc < 300)       begin p_on = 100; p_cont = 100; p_drain = 100; end
            else if (cyc < 600)  begin p_on = 70;  p_cont = 80;  p_drain = 45;  end
            else if (cyc < 900)  begin p_on = 100; p_cont = 100; p_drain = 100; end
            else if (cyc < 1200) begin p_on = 15;  p_cont = 40;  p_drain = 80;  end
            else                 begin p_on = 60;  p_cont = 60;  p_drain = 30;  end

            @(negedge clk);
            exp_ready = '0;
            if (own >= 0) exp_ready[own] = ready_s;
            check("grant", W'(grant), (own >= 0) ? W'(1 << own) : '0);
            check("busy", W'(busy), W'(own >= 0));
            check("valid_s", W'(valid_s), (own >= 0) ? W'(vld[own]) : '0);
            check("datain", datain, (own >= 0) ? dat[own] : '0);
            check("req_ready", W'(req_ready), W'(exp_ready));

            beat   = (own >= 0) && vld[own] && ready_s;
            beat_r = beat ? own : -1;

            @(posedge clk);
            #1;
            if (rst_n) begin
                if (own < 0) begin
                    if (|vld) begin own = pick(vld, last); cnt = 0; end
                end else begin
                    rel = (beat && cnt == MB - 1) || !vld[own];
                    if (rel) begin
                        last = own;
                        cnt  = 0;
                        own  = (|vld) ? pick(vld, own) : -1;
                    end else if (beat) begin
                        cnt++;
                    end
                end
            end

            if (beat) fifo_lvl++;
            if (fifo_lvl > 0 && $urandom_range(99) < p_drain) fifo_lvl--;

            for (int r = 0; r < N; r++) begin
                if (beat_r == r) begin
                    if ($urandom_range(99) < p_cont) dat[r] = $urandom;
                    else vld[r] = 1'b0;
                end else if (!vld[r] && $urandom_range(99) < p_on) begin
                    vld[r] = 1'b1;
                    dat[r] = $urandom;
                end
            end

            if (cyc == 2 || cyc == 604 || cyc == 1403) rst_n = 1'b1;
            if (cyc == 601 || cyc == 1400) begin
                rst_n = 1'b0;
                model_reset();
                vld = '1;
            end
            drive();
            if (!rst_n) begin
                #1;
                check("rst_grant", W'(grant), '0);
                check("rst_ready", W'(req_ready), '0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
